// File: rtl/core_lsu_ucwbuf_pkg.sv
// ============================================================================
// core_lsu_ucwbuf_pkg
// Shared types for the uncached write buffer: entry layout, FSM states and
// the store-merge helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package core_lsu_ucwbuf_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strobe;
        logic [1:0]  size;
    } ucwb_entry_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } ucwb_state_e;

    // Smallest naturally aligned access covering the strobe; anything else is a word.
    function automatic logic [1:0] strobe_size(input logic [3:0] strobe);
        logic [1:0] size;
        case (strobe)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 2'd0;
            4'b0011, 4'b1100:                   size = 2'd1;
            default:                            size = 2'd2;
        endcase
        return size;
    endfunction

    function automatic ucwb_entry_t merge_entry(input ucwb_entry_t old_e,
                                                input ucwb_entry_t new_e);
        ucwb_entry_t m;
        m = old_e;
        for (int b = 0; b < 4; b++) begin
            if (new_e.strobe[b]) begin
                m.data[8*b +: 8] = new_e.data[8*b +: 8];
            end
        end
        m.strobe = old_e.strobe | new_e.strobe;
        m.size   = strobe_size(m.strobe);
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/core_lsu_ucwbuf_ring.sv
// ============================================================================
// core_lsu_ucwbuf_ring
// In-order entry storage with head/tail pointers, occupancy count and the
// word-address hazard compare. Store merging under LSU_UCWB_MERGE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module core_lsu_ucwbuf_ring
    import core_lsu_ucwbuf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid_i,
    input  ucwb_entry_t                push_entry_i,
    input  logic                       head_busy_i,
    input  logic                       pop_i,
    input  logic [29:0]                hazard_word_i,
    output logic                       push_ready_o,
    output ucwb_entry_t                head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [$clog2(DEPTH):0]     count_next_o,
    output logic                       hazard_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    ucwb_entry_t     mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [PW-1:0]   last_idx;
    logic            merge_hit;
    logic            push_acc;
    logic            push_new;
    logic            merge;

    assign last_idx = tail_q - 1'b1;

`ifdef LSU_UCWB_MERGE_EN
    // The in-flight head is already on the bus and must not change underneath it.
    assign merge_hit = valid_q[last_idx]
                    && (mem_q[last_idx].addr[31:2] == push_entry_i.addr[31:2])
                    && !(head_busy_i && (last_idx == head_q));
`else
    logic unused_head_busy;
    assign unused_head_busy = head_busy_i;
    assign merge_hit = 1'b0;
`endif

    assign push_ready_o = (count_q != FULL) || merge_hit;
    assign push_acc     = push_valid_i && push_ready_o;
    assign merge        = push_acc && merge_hit;
    assign push_new     = push_acc && !merge_hit;
    assign count_d      = count_q + CW'(push_new) - CW'(pop_i);

    assign head_o       = mem_q[head_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;

    always_comb begin
        hazard_o = push_acc && (push_entry_i.addr[31:2] == hazard_word_i);
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (mem_q[i].addr[31:2] == hazard_word_i)) begin
                hazard_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (push_new) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            if (pop_i) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
        end
    end

    // Payload needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (push_new) begin
            mem_q[tail_q] <= push_entry_i;
        end else if (merge) begin
            mem_q[last_idx] <= merge_entry(mem_q[last_idx], push_entry_i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/core_lsu_ucwbuf.sv
// ============================================================================
// core_lsu_ucwbuf
// Uncached write buffer: queues LSU stores and drains them as single-beat bus
// writes. Optional store merging via LSU_UCWB_MERGE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module core_lsu_ucwbuf
    import core_lsu_ucwbuf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_valid_i,
    output logic        push_ready_o,
    input  logic [31:0] push_addr_i,
    input  logic [31:0] push_data_i,
    input  logic [3:0]  push_strobe_i,
    input  logic [1:0]  push_size_i,
    input  logic        bus_grant_i,
    output logic        bus_valid_o,
    output logic        bus_write_o,
    output logic [31:0] bus_addr_o,
    output logic [1:0]  bus_size_o,
    output logic [3:0]  bus_wstrobe_o,
    output logic [31:0] bus_wdata_o,
    output logic        bus_data_valid_o,
    output logic        bus_data_last_o,
    input  logic        bus_ready_i,
    input  logic        bus_data_ok_i,
    input  logic [31:0] hazard_addr_i,
    output logic        hazard_o,
    output logic        busy_o,
    output logic        empty_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    ucwb_state_e   state_q;
    ucwb_state_e   state_d;
    ucwb_entry_t   push_entry;
    ucwb_entry_t   head;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          pop;
    logic          unused_hazard_lsbs;

    assign unused_hazard_lsbs = ^hazard_addr_i[1:0];

    assign push_entry = '{addr: push_addr_i, data: push_data_i,
                          strobe: push_strobe_i, size: push_size_i};
    assign pop        = (state_q == S_DATA) && bus_data_ok_i;

    core_lsu_ucwbuf_ring #(
        .DEPTH(DEPTH)
    ) u_ring (
        .clk           (clk),
        .rst           (rst),
        .push_valid_i  (push_valid_i),
        .push_entry_i  (push_entry),
        .head_busy_i   (state_q != S_IDLE),
        .pop_i         (pop),
        .hazard_word_i (hazard_addr_i[31:2]),
        .push_ready_o  (push_ready_o),
        .head_o        (head),
        .count_o       (count),
        .count_next_o  (count_next),
        .hazard_o      (hazard_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant is only sampled when a new transaction could start; S_ADDR never aborts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if ((count != '0) && bus_grant_i) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (bus_ready_i) state_d = S_DATA;
            end
            S_DATA: begin
                if (bus_data_ok_i) begin
                    state_d = ((count_next != '0) && bus_grant_i) ? S_ADDR : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus_valid_o      = (state_q == S_ADDR);
    assign bus_write_o      = (state_q == S_ADDR);
    assign bus_data_valid_o = (state_q == S_DATA);
    assign bus_data_last_o  = (state_q == S_DATA);
    assign bus_addr_o       = head.addr;
    assign bus_size_o       = head.size;
    assign bus_wstrobe_o    = head.strobe;
    assign bus_wdata_o      = head.data;

    assign empty_o = (count == '0);
    assign busy_o  = !empty_o || (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_core_lsu_ucwbuf.sv
// ============================================================================
// tb_core_lsu_ucwbuf
// Directed plus randomized stimulus against a queue-based reference of the
// write buffer (default build, merging disabled).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_core_lsu_ucwbuf;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  size;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid_i;
    logic        push_ready_o;
    logic [31:0] push_addr_i;
    logic [31:0] push_data_i;
    logic [3:0]  push_strobe_i;
    logic [1:0]  push_size_i;
    logic        bus_grant_i;
    logic        bus_valid_o;
    logic        bus_write_o;
    logic [31:0] bus_addr_o;
    logic [1:0]  bus_size_o;
    logic [3:0]  bus_wstrobe_o;
    logic [31:0] bus_wdata_o;
    logic        bus_data_valid_o;
    logic        bus_data_last_o;
    logic        bus_ready_i;
    logic        bus_data_ok_i;
    logic [31:0] hazard_addr_i;
    logic        hazard_o;
    logic        busy_o;
    logic        empty_o;

    core_lsu_ucwbuf #(.DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .push_valid_i     (push_valid_i),
        .push_ready_o     (push_ready_o),
        .push_addr_i      (push_addr_i),
        .push_data_i      (push_data_i),
        .push_strobe_i    (push_strobe_i),
        .push_size_i      (push_size_i),
        .bus_grant_i      (bus_grant_i),
        .bus_valid_o      (bus_valid_o),
        .bus_write_o      (bus_write_o),
        .bus_addr_o       (bus_addr_o),
        .bus_size_o       (bus_size_o),
        .bus_wstrobe_o    (bus_wstrobe_o),
        .bus_wdata_o      (bus_wdata_o),
        .bus_data_valid_o (bus_data_valid_o),
        .bus_data_last_o  (bus_data_last_o),
        .bus_ready_i      (bus_ready_i),
        .bus_data_ok_i    (bus_data_ok_i),
        .hazard_addr_i    (hazard_addr_i),
        .hazard_o         (hazard_o),
        .busy_o           (busy_o),
        .empty_o          (empty_o)
    );

    always #5 clk = ~clk;

    // Reference: pending stores in push order; phase 0 = no transaction,
    // 1 = address phase of the oldest store, 2 = its data phase.
    ent_t q[$];
    int   phase = 0;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_model();
        int   n;
        logic hz;
        n  = q.size();
        hz = push_valid_i && (n != 4) && (push_addr_i[31:2] == hazard_addr_i[31:2]);
        foreach (q[i]) if (q[i].addr[31:2] == hazard_addr_i[31:2]) hz = 1'b1;
        chk("push_ready", {31'd0, push_ready_o}, {31'd0, n != 4});
        chk("empty", {31'd0, empty_o}, {31'd0, n == 0});
        chk("busy", {31'd0, busy_o}, {31'd0, (n != 0) || (phase != 0)});
        chk("bus_valid", {31'd0, bus_valid_o}, {31'd0, phase == 1});
        chk("data_valid", {31'd0, bus_data_valid_o}, {31'd0, phase == 2});
        chk("data_last", {31'd0, bus_data_last_o}, {31'd0, phase == 2});
        chk("hazard", {31'd0, hazard_o}, {31'd0, hz});
        if (phase == 1) begin
            chk("bus_write", {31'd0, bus_write_o}, 32'd1);
            chk("bus_addr", bus_addr_o, q[0].addr);
            chk("bus_size", {30'd0, bus_size_o}, {30'd0, q[0].size});
        end
        if (phase == 2) begin
            chk("bus_wdata", bus_wdata_o, q[0].data);
            chk("bus_wstrobe", {28'd0, bus_wstrobe_o}, {28'd0, q[0].strb});
        end
    endtask

    // Inputs are already set (just after a falling edge); check, clock, advance model.
    task automatic cycle();
        int   n;
        logic acc;
        logic pop;
        #1;
        check_model();
        @(posedge clk);
        n   = q.size();
        acc = push_valid_i && (n != 4);
        pop = (phase == 2) && bus_data_ok_i;
        if (rst) begin
            q.delete();
            phase = 0;
        end else begin
            case (phase)
                0: phase = ((n != 0) && bus_grant_i) ? 1 : 0;
                1: phase = bus_ready_i ? 2 : 1;
                default: if (bus_data_ok_i)
                    phase = ((n - int'(pop) + int'(acc) != 0) && bus_grant_i) ? 1 : 0;
            endcase
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{push_addr_i, push_data_i, push_strobe_i, push_size_i});
        end
        @(negedge clk);
    endtask

    task automatic set_push(input logic v, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] z);
        push_valid_i  = v;
        push_addr_i   = a;
        push_data_i   = d;
        push_strobe_i = s;
        push_size_i   = z;
    endtask

    initial begin
        rst = 1'b1;
        set_push(1'b0, 32'h0, 32'h0, 4'h0, 2'd0);
        bus_grant_i = 1'b0;
        bus_ready_i = 1'b0;
        bus_data_ok_i = 1'b0;
        hazard_addr_i = 32'h0;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;

        // Reset values
        chk("rst_push_ready", {31'd0, push_ready_o}, 32'd1);
        chk("rst_bus_valid", {31'd0, bus_valid_o}, 32'd0);
        chk("rst_data_valid", {31'd0, bus_data_valid_o}, 32'd0);
        chk("rst_data_last", {31'd0, bus_data_last_o}, 32'd0);
        chk("rst_hazard", {31'd0, hazard_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_empty", {31'd0, empty_o}, 32'd1);

        // Single store with grant held: address phase two cycles after the push
        bus_grant_i = 1'b1; bus_ready_i = 1'b1; bus_data_ok_i = 1'b1;
        set_push(1'b1, 32'h1FE0_0000, 32'hDEAD_BEEF, 4'hF, 2'd2);
        cycle();
        set_push(1'b0, 32'h0, 32'h0, 4'h0, 2'd0);
        cycle();
        chk("t1_bus_valid", {31'd0, bus_valid_o}, 32'd1);
        chk("t1_bus_addr", bus_addr_o, 32'h1FE0_0000);
        cycle();
        chk("t1_data_valid", {31'd0, bus_data_valid_o}, 32'd1);
        chk("t1_wdata", bus_wdata_o, 32'hDEAD_BEEF);
        chk("t1_wstrobe", {28'd0, bus_wstrobe_o}, 32'hF);
        cycle();
        chk("t1_empty", {31'd0, empty_o}, 32'd1);
        chk("t1_busy", {31'd0, busy_o}, 32'd0);

        // Fill with grant low, hold a fifth push, then drain in order
        bus_grant_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_push(1'b1, 32'h4000_0000 + 32'(i * 16), 32'h1111_0000 + 32'(i), 4'hF, 2'd2);
            cycle();
        end
        set_push(1'b1, 32'h4000_0100, 32'h5555_5555, 4'h3, 2'd1);
        chk("full_ready", {31'd0, push_ready_o}, 32'd0);
        cycle();
        cycle();
        bus_grant_i = 1'b1;
        cycle();
        cycle();
        chk("full_pop_ready", {31'd0, push_ready_o}, 32'd0);
        chk("full_pop_dv", {31'd0, bus_data_valid_o}, 32'd1);
        cycle();
        chk("after_pop_ready", {31'd0, push_ready_o}, 32'd1);
        cycle();
        set_push(1'b0, 32'h0, 32'h0, 4'h0, 2'd0);
        for (int i = 0; i < 12; i++) cycle();
        chk("drain_empty", {31'd0, empty_o}, 32'd1);

        // Word-address hazard
        bus_grant_i = 1'b0;
        set_push(1'b1, 32'h8000_0104, 32'hCAFE_F00D, 4'h1, 2'd0);
        cycle();
        set_push(1'b0, 32'h0, 32'h0, 4'h0, 2'd0);
        hazard_addr_i = 32'h8000_0106;
        #1 chk("hz_match", {31'd0, hazard_o}, 32'd1);
        hazard_addr_i = 32'h8000_0108;
        #1 chk("hz_miss", {31'd0, hazard_o}, 32'd0);
        cycle();

        // Reset while in the data phase
        bus_grant_i = 1'b1; bus_ready_i = 1'b1; bus_data_ok_i = 1'b0;
        cycle();
        cycle();
        chk("pre_rst_dv", {31'd0, bus_data_valid_o}, 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_dv", {31'd0, bus_data_valid_o}, 32'd0);
        chk("rst_empty2", {31'd0, empty_o}, 32'd1);
        chk("rst_busy2", {31'd0, busy_o}, 32'd0);

        // Randomized traffic against the reference
        for (int i = 0; i < 500; i++) begin
            set_push($urandom_range(0, 1) == 1,
                     32'h8000_0000 | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3),
                     $urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 2)));
            bus_grant_i   = $urandom_range(0, 9) < 7;
            bus_ready_i   = $urandom_range(0, 9) < 6;
            bus_data_ok_i = $urandom_range(0, 9) < 6;
            hazard_addr_i = 32'h8000_0000 | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            cycle();
        end

        set_push(1'b0, 32'h0, 32'h0, 4'h0, 2'd0);
        bus_grant_i = 1'b1; bus_ready_i = 1'b1; bus_data_ok_i = 1'b1;
        for (int i = 0; i < 16; i++) cycle();
        chk("final_empty", {31'd0, empty_o}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
